decode_stage: RTL and testbench

- Buffered, handshaked RV32I decode stage. It is the pipelined successor to the combinational instruction decoder and sits between fetch and execute.
- Accepts raw instruction/PC pairs over valid/ready into a small in-order queue. Decodes them into registered control fields.
- Adds over the combinational decoder: optional M-extension, illegal-instruction detection, flush, store-only byte enables, and a decoded-instruction counter.

---
 rtl/decode_stage.sv | 206 ++++++++++++++++++++
 tb/tb_decode_stage.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Buffered RV32I decode stage: raw instr/PC enter a small in-order queue and leave
// as a registered decoded bundle over valid/ready; supports flush and a delivered-bundle counter.
module decode_stage #(
    parameter int DATA_WIDTH  = 32,
    parameter int QUEUE_DEPTH = 2,
    parameter bit ENABLE_M    = 1'b1,
    parameter int COUNT_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_instr,
    input  logic [DATA_WIDTH-1:0] in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic [4:0]            rs1,
    output logic [4:0]            rs2,
    output logic [4:0]            rd,
    output logic [4:0]            alu_select,
    output logic [3:0]            we,
    output logic [2:0]            funct3,
    output logic [31:0]           immediate,
    output logic                  alu_inb_imm_select,
    output logic                  alu_ina_pc_select,
    output logic                  rd_din_pc_select,
    output logic [10:0]           op_class,
    output logic                  illegal,
    output logic [COUNT_W-1:0]    decode_count
);
    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam logic [AW:0]        PTR_ONE = 1;
    localparam logic [COUNT_W-1:0] CNT_ONE = 1;

    localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6F, OP_JALR = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63, OP_LOAD = 7'h03, OP_STORE = 7'h23, OP_IMM = 7'h13;
    localparam logic [6:0] OP_ALU = 7'h33, OP_FENCE = 7'h0F, OP_SYSTEM = 7'h73;

    localparam int C_LUI = 0, C_AUIPC = 1, C_JAL = 2, C_JALR = 3, C_BRANCH = 4, C_LOAD = 5;
    localparam int C_STORE = 6, C_IMM = 7, C_ALU = 8, C_FENCE = 9, C_SYSTEM = 10;

    logic [DATA_WIDTH-1:0] r_q_instr [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0] r_q_pc    [QUEUE_DEPTH];
    logic [AW:0]           r_wr_ptr, r_rd_ptr;

    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_pc;
    logic [4:0]            r_rs1, r_rs2, r_rd, r_alu;
    logic [3:0]            r_we;
    logic [2:0]            r_f3;
    logic [31:0]           r_imm;
    logic                  r_inb, r_ina, r_rdpc, r_ill;
    logic [10:0]           r_opc;
    logic [COUNT_W-1:0]    r_count;

    logic                  w_q_empty, w_q_full, w_push_hs, w_out_hs, w_load, w_q_push;
    logic [DATA_WIDTH-1:0] w_src_instr, w_src_pc;
    logic [6:0]            w_op, w_f7;
    logic [2:0]            w_f3;
    logic [10:0]           w_cls, w_opc;
    logic                  w_bad;
    logic [31:0]           w_imm;
    logic [4:0]            w_rs1, w_rd, w_alu;
    logic [3:0]            w_we;
    logic                  w_inb, w_ina, w_rdpc;

    // Extra wrap bit on the pointers separates full from empty.
    assign w_q_empty = (r_wr_ptr == r_rd_ptr);
    assign w_q_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign in_ready  = !flush && !w_q_full;
    assign w_push_hs = in_valid && in_ready;
    assign w_out_hs  = r_out_valid && out_ready;
    assign w_load    = !r_out_valid || out_ready;
    // Input may bypass into the output register only when nothing older is queued.
    assign w_q_push  = w_push_hs && !(w_load && w_q_empty);

    assign w_src_instr = w_q_empty ? in_instr : r_q_instr[r_rd_ptr[AW-1:0]];
    assign w_src_pc    = w_q_empty ? in_pc    : r_q_pc[r_rd_ptr[AW-1:0]];
    assign w_op = w_src_instr[6:0];
    assign w_f3 = w_src_instr[14:12];
    assign w_f7 = w_src_instr[31:25];

    always_comb begin
        w_cls = '0;
        w_bad = 1'b0;
        w_imm = {{20{w_src_instr[31]}}, w_src_instr[31:20]};
        case (w_op)
            OP_LUI:    begin w_cls[C_LUI] = 1'b1; w_imm = {w_src_instr[31:12], 12'b0}; end
            OP_AUIPC:  begin w_cls[C_AUIPC] = 1'b1; w_imm = {w_src_instr[31:12], 12'b0}; end
            OP_JAL: begin
                w_cls[C_JAL] = 1'b1;
                w_imm = {{12{w_src_instr[31]}}, w_src_instr[19:12], w_src_instr[20],
                         w_src_instr[30:21], 1'b0};
            end
            OP_JALR:   begin w_cls[C_JALR] = 1'b1; w_bad = (w_f3 != 3'b000); end
            OP_BRANCH: begin
                w_cls[C_BRANCH] = 1'b1;
                w_bad = (w_f3[2:1] == 2'b01);
                w_imm = {{20{w_src_instr[31]}}, w_src_instr[7], w_src_instr[30:25],
                         w_src_instr[11:8], 1'b0};
            end
            OP_LOAD:   begin
                w_cls[C_LOAD] = 1'b1;
                w_bad = (w_f3 == 3'b011) || (w_f3[2:1] == 2'b11);
            end
            OP_STORE:  begin
                w_cls[C_STORE] = 1'b1;
                w_bad = (w_f3 >= 3'b011);
                w_imm = {{20{w_src_instr[31]}}, w_src_instr[31:25], w_src_instr[11:7]};
            end
            OP_IMM:    begin
                w_cls[C_IMM] = 1'b1;
                w_bad = ((w_f3 == 3'b001) && (w_f7 != 7'h00)) ||
                        ((w_f3 == 3'b101) && (w_f7 != 7'h00) && (w_f7 != 7'h20));
            end
            OP_ALU:    begin
                w_cls[C_ALU] = 1'b1;
                w_bad = !((w_f7 == 7'h00) ||
                          ((w_f7 == 7'h20) && ((w_f3 == 3'b000) || (w_f3 == 3'b101))) ||
                          (ENABLE_M && (w_f7 == 7'h01)));
            end
            OP_FENCE:  w_cls[C_FENCE] = 1'b1;
            OP_SYSTEM: w_cls[C_SYSTEM] = 1'b1;
            default:   w_bad = 1'b1;  // also catches instr[1:0] != 2'b11
        endcase
    end

    always_comb begin
        w_opc = w_bad ? 11'b0 : w_cls;
        w_rs1 = (w_cls[C_LUI] || w_cls[C_FENCE]) ? 5'd0 : w_src_instr[19:15];
        w_rd  = (w_bad || w_cls[C_FENCE] || w_cls[C_BRANCH] || w_cls[C_STORE]) ? 5'd0
                                                                                : w_src_instr[11:7];
        w_we  = 4'b0000;
        if (w_opc[C_STORE]) begin
            case (w_f3)
                3'b000:  w_we = 4'b0001;
                3'b001:  w_we = 4'b0011;
                3'b010:  w_we = 4'b1111;
                default: w_we = 4'b0000;
            endcase
        end
        w_alu = 5'b00000;
        if (w_opc[C_IMM])
            w_alu = {1'b0, (w_f3 == 3'b101) & w_src_instr[30], w_f3};
        else if (w_opc[C_ALU])
            w_alu = {ENABLE_M & w_src_instr[25], w_src_instr[30], w_f3};
        w_inb  = |w_opc[C_IMM:C_LUI];
        w_ina  = w_opc[C_JAL] | w_opc[C_AUIPC];
        w_rdpc = w_opc[C_JAL] | w_opc[C_JALR];
    end

    always_ff @(posedge clk) begin
        if (w_q_push) begin
            r_q_instr[r_wr_ptr[AW-1:0]] <= in_instr;
            r_q_pc[r_wr_ptr[AW-1:0]]    <= in_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;  r_rd_ptr <= '0;  r_out_valid <= 1'b0;  r_out_pc <= '0;
            r_rs1 <= '0;  r_rs2 <= '0;  r_rd <= '0;  r_alu <= '0;  r_we <= '0;  r_f3 <= '0;
            r_imm <= '0;  r_inb <= 1'b0;  r_ina <= 1'b0;  r_rdpc <= 1'b0;  r_opc <= '0;
            r_ill <= 1'b0;  r_count <= '0;
        end else begin
            if (w_out_hs)
                r_count <= r_count + CNT_ONE;
            if (flush) begin
                r_rd_ptr    <= r_wr_ptr;
                r_out_valid <= 1'b0;
            end else begin
                if (w_q_push)
                    r_wr_ptr <= r_wr_ptr + PTR_ONE;
                if (w_load) begin
                    r_out_valid <= !w_q_empty || w_push_hs;
                    if (!w_q_empty)
                        r_rd_ptr <= r_rd_ptr + PTR_ONE;
                    if (!w_q_empty || w_push_hs) begin
                        r_out_pc <= w_src_pc;  r_rs1 <= w_rs1;  r_rs2 <= w_src_instr[24:20];
                        r_rd <= w_rd;  r_alu <= w_alu;  r_we <= w_we;  r_f3 <= w_f3;
                        r_imm <= w_imm;  r_inb <= w_inb;  r_ina <= w_ina;  r_rdpc <= w_rdpc;
                        r_opc <= w_opc;  r_ill <= w_bad;
                    end
                end
            end
        end
    end

    assign out_valid          = r_out_valid;
    assign out_pc             = r_out_pc;
    assign rs1                = r_rs1;
    assign rs2                = r_rs2;
    assign rd                 = r_rd;
    assign alu_select         = r_alu;
    assign we                 = r_we;
    assign funct3             = r_f3;
    assign immediate          = r_imm;
    assign alu_inb_imm_select = r_inb;
    assign alu_ina_pc_select  = r_ina;
    assign rd_din_pc_select   = r_rdpc;
    assign op_class           = r_opc;
    assign illegal            = r_ill;
    assign decode_count       = r_count;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed decode cases, backpressure, flush, reset and a
// randomized run against a queue-based reference model; a second instance has ENABLE_M=0.
module tb_decode_stage;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [4:0] rs1; logic [4:0] rs2; logic [4:0] rd; logic [4:0] alu;
        logic [3:0] we; logic [2:0] f3; logic [31:0] imm;
        logic inb; logic ina; logic rdpc; logic [10:0] cls; logic ill;
    } dec_t;
    typedef struct packed { logic [31:0] instr; logic [31:0] pc; } item_t;

    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in_instr = '0, in_pc = '0;

    logic in_ready, out_valid, inb, ina, rdpc, ill;
    logic [31:0] out_pc, imm, decode_count;
    logic [4:0] rs1, rs2, rd, alu;
    logic [3:0] we;
    logic [2:0] f3;
    logic [10:0] cls;
    logic nm_in_ready, nm_out_valid, nm_inb, nm_ina, nm_rdpc, nm_ill;
    logic [31:0] nm_out_pc, nm_imm, nm_decode_count;
    logic [4:0] nm_rs1, nm_rs2, nm_rd, nm_alu;
    logic [3:0] nm_we;
    logic [2:0] nm_f3;
    logic [10:0] nm_cls;
    dec_t got, nm_got;

    int n_chk = 0, n_fail = 0;
    logic [31:0] exp_cnt = '0;

    decode_stage #(.DATA_WIDTH(32), .QUEUE_DEPTH(DEPTH), .ENABLE_M(1'b1), .COUNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .rs1(rs1), .rs2(rs2), .rd(rd), .alu_select(alu), .we(we), .funct3(f3),
        .immediate(imm), .alu_inb_imm_select(inb), .alu_ina_pc_select(ina),
        .rd_din_pc_select(rdpc), .op_class(cls), .illegal(ill), .decode_count(decode_count));

    decode_stage #(.DATA_WIDTH(32), .QUEUE_DEPTH(DEPTH), .ENABLE_M(1'b0), .COUNT_W(32)) dut_nm (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(nm_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(nm_out_valid), .out_ready(out_ready),
        .out_pc(nm_out_pc), .rs1(nm_rs1), .rs2(nm_rs2), .rd(nm_rd), .alu_select(nm_alu),
        .we(nm_we), .funct3(nm_f3), .immediate(nm_imm), .alu_inb_imm_select(nm_inb),
        .alu_ina_pc_select(nm_ina), .rd_din_pc_select(nm_rdpc), .op_class(nm_cls),
        .illegal(nm_ill), .decode_count(nm_decode_count));

    assign got    = {rs1, rs2, rd, alu, we, f3, imm, inb, ina, rdpc, cls, ill};
    assign nm_got = {nm_rs1, nm_rs2, nm_rd, nm_alu, nm_we, nm_f3, nm_imm, nm_inb, nm_ina,
                     nm_rdpc, nm_cls, nm_ill};

    always #5 clk = ~clk;

    // Reference decode: class index k is the op_class bit position, immediates by arithmetic.
    function automatic dec_t ref_dec(input logic [31:0] ins, input bit m_en);
        dec_t d;
        int k;
        bit ok;
        logic [2:0] fn3;
        logic [6:0] fn7;
        logic [31:0] sgn;
        fn3 = ins[14:12];
        fn7 = ins[31:25];
        case (ins[6:0])
            7'h37: k = 0;  7'h17: k = 1;  7'h6F: k = 2;  7'h67: k = 3;
            7'h63: k = 4;  7'h03: k = 5;  7'h23: k = 6;  7'h13: k = 7;
            7'h33: k = 8;  7'h0F: k = 9;  7'h73: k = 10;
            default: k = -1;
        endcase
        ok = (k >= 0);
        if (k == 3) ok = (fn3 == 0);
        if (k == 4) ok = !(fn3 inside {3'd2, 3'd3});
        if (k == 5) ok = fn3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        if (k == 6) ok = (fn3 < 3);
        if (k == 7 && fn3 == 1) ok = (fn7 == 0);
        if (k == 7 && fn3 == 5) ok = fn7 inside {7'h00, 7'h20};
        if (k == 8) ok = (fn7 == 0) || (fn7 == 7'h20 && fn3 inside {3'd0, 3'd5}) ||
                         (m_en && fn7 == 7'h01);
        sgn = ins[31] ? 32'hFFFF_FFFF : 32'h0;
        case (k)
            0, 1:    d.imm = ins & 32'hFFFF_F000;
            2:       d.imm = (sgn << 20) + ins[19:12] * 4096 + ins[20] * 2048 + ins[30:21] * 2;
            4:       d.imm = (sgn << 12) + ins[7] * 2048 + ins[30:25] * 32 + ins[11:8] * 2;
            6:       d.imm = (sgn << 11) + ins[30:25] * 32 + ins[11:7];
            default: d.imm = (sgn << 11) + ins[30:20];
        endcase
        d.f3  = fn3;
        d.rs2 = ins[24:20];
        d.rs1 = (k == 0 || k == 9) ? 5'd0 : ins[19:15];
        d.rd  = (!ok || k inside {4, 6, 9}) ? 5'd0 : ins[11:7];
        d.cls = '0; d.we = '0; d.alu = '0; d.inb = 0; d.ina = 0; d.rdpc = 0;
        d.ill = !ok;
        if (ok) begin
            d.cls = 11'(1 << k);
            if (k == 6) d.we = 4'((1 << (1 << fn3)) - 1);
            if (k == 7) d.alu = {1'b0, (fn3 == 5) ? ins[30] : 1'b0, fn3};
            if (k == 8) d.alu = {m_en ? ins[25] : 1'b0, ins[30], fn3};
            d.inb  = (k <= 7);
            d.ina  = (k == 1 || k == 2);
            d.rdpc = (k == 2 || k == 3);
        end
        return d;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 15) == 0) return w;
        case ($urandom_range(0, 10))
            0: w[6:0] = 7'h37;  1: w[6:0] = 7'h17;  2: w[6:0] = 7'h6F;  3: w[6:0] = 7'h67;
            4: w[6:0] = 7'h63;  5: w[6:0] = 7'h03;  6: w[6:0] = 7'h23;  7: w[6:0] = 7'h13;
            8: w[6:0] = 7'h33;  9: w[6:0] = 7'h0F;  default: w[6:0] = 7'h73;
        endcase
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;  1: w[31:25] = 7'h20;  2: w[31:25] = 7'h01;  default: ;
        endcase
        return w;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = '0;
    endtask

    task automatic test_reset();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_instr = 32'hFFF0_0093; in_pc = 32'h40 + 4 * i;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_chk++; if (decode_count !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", decode_count); end
        n_chk++; if (got !== '0) begin n_fail++; $display("FAIL reset_bundle: got %h expected 0", got); end
        n_chk++; if (out_pc !== 32'd0) begin n_fail++; $display("FAIL reset_out_pc: got %h expected 0", out_pc); end
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    logic [31:0] t_ins  [7] = '{32'hFFF00093, 32'h402081B3, 32'h4030D093, 32'h022081B3,
                                32'h0020A223, 32'h0000A103, 32'h00003003};
    logic [4:0]  t_alu  [7] = '{5'b00000, 5'b01000, 5'b01101, 5'b10000, 5'b00000, 5'b00000, 5'b00000};
    logic        t_ill  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        t_nill [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [3:0]  t_we   [7] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000};
    logic [31:0] t_imm  [7] = '{32'hFFFFFFFF, 32'h0, 32'h00000403, 32'h0, 32'h4, 32'h0, 32'h0};
    logic        t_cimm [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    task automatic test_decode();
        dec_t e;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_instr = t_ins[i]; in_pc = 32'h1000 + 4 * i; out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            e = ref_dec(t_ins[i], 1'b1);
            n_chk++; if (out_valid !== 1'b1 || got !== e) begin n_fail++; $display("FAIL decode_bundle[%0d]: got %h expected %h", i, got, e); end
            e = ref_dec(t_ins[i], 1'b0);
            n_chk++; if (nm_got !== e) begin n_fail++; $display("FAIL decode_bundle_nom[%0d]: got %h expected %h", i, nm_got, e); end
            n_chk++; if (alu !== t_alu[i]) begin n_fail++; $display("FAIL decode_alu[%0d]: got %b expected %b", i, alu, t_alu[i]); end
            n_chk++; if (ill !== t_ill[i]) begin n_fail++; $display("FAIL decode_illegal[%0d]: got %b expected %b", i, ill, t_ill[i]); end
            n_chk++; if (nm_ill !== t_nill[i]) begin n_fail++; $display("FAIL decode_illegal_nom[%0d]: got %b expected %b", i, nm_ill, t_nill[i]); end
            n_chk++; if (we !== t_we[i]) begin n_fail++; $display("FAIL decode_we[%0d]: got %b expected %b", i, we, t_we[i]); end
            n_chk++; if (out_pc !== 32'h1000 + 4 * i) begin n_fail++; $display("FAIL decode_pc[%0d]: got %h expected %h", i, out_pc, 32'h1000 + 4 * i); end
            if (t_cimm[i]) begin
                n_chk++; if (imm !== t_imm[i]) begin n_fail++; $display("FAIL decode_imm[%0d]: got %h expected %h", i, imm, t_imm[i]); end
            end
        end
    endtask

    task automatic test_backpressure();
        item_t q[$];
        int acc, seen;
        bit pushed4;
        dec_t e;
        do_reset();
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_instr = 32'h00000013 | ((i + 1) << 7); in_pc = 32'h100 + 4 * i;
            #1;
            if (in_ready) begin acc++; q.push_back(item_t'{instr: in_instr, pc: in_pc}); end
        end
        n_chk++; if (acc != 3) begin n_fail++; $display("FAIL bp_accepted: got %0d expected 3", acc); end
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_full: got %b expected 0", in_ready); end
        seen = 0; pushed4 = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 30 && seen < 4; c++) begin
            if (c > 0) @(negedge clk);
            if (pushed4) in_valid = 1'b0;
            #1;
            if (out_valid && q.size() > 0) begin
                e = ref_dec(q[0].instr, 1'b1);
                n_chk++; if (out_pc !== q[0].pc || got !== e) begin n_fail++; $display("FAIL bp_order[%0d]: got pc %h expected pc %h", seen, out_pc, q[0].pc); end
                void'(q.pop_front());
                seen++;
            end
            if (in_valid && in_ready) begin pushed4 = 1; q.push_back(item_t'{instr: in_instr, pc: in_pc}); end
            if (c < 29) begin end
        end
        n_chk++; if (seen != 4) begin n_fail++; $display("FAIL bp_drain_timeout: got %0d bundles expected 4", seen); end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_chk++; if (decode_count !== 32'd4) begin n_fail++; $display("FAIL bp_count: got %0d expected 4", decode_count); end
    endtask

    task automatic test_flush();
        int acc;
        do_reset();
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h200 + 4 * c;
            #1;
            if (!in_ready) break;
            acc++;
        end
        n_chk++; if (acc != 3) begin n_fail++; $display("FAIL flush_fill: got %0d expected 3", acc); end
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; in_pc = 32'hDEAD0;
        #1;
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b expected 0", out_valid); end
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_empty: got %b expected 1", in_ready); end
        n_chk++; if (decode_count !== 32'd0) begin n_fail++; $display("FAIL flush_count: got %0d expected 0", decode_count); end
        @(negedge clk);
        in_valid = 1'b1; in_pc = 32'h300; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_chk++; if (out_valid !== 1'b1 || out_pc !== 32'h300) begin n_fail++; $display("FAIL flush_next: got pc %h expected 300", out_pc); end
        // Refill, then flush while the held bundle is being consumed: that handshake still counts.
        @(negedge clk);
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid = 1'b1; in_pc = 32'h400 + 4 * c;
            #1;
            if (!in_ready) break;
        end
        @(negedge clk);
        flush = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        #1;
        n_chk++; if (decode_count !== 32'd2) begin n_fail++; $display("FAIL flush_hs_count: got %0d expected 2", decode_count); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_hs_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_random();
        item_t mq[$];
        logic [31:0] pcn;
        logic er, ev;
        dec_t e;
        do_reset();
        pcn = 32'h8000;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = gen_instr();
            in_pc     = pcn;
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            #1;
            er = !flush && (mq.size() <= DEPTH);
            ev = (mq.size() > 0);
            n_chk++; if (in_ready !== er) begin n_fail++; $display("FAIL rnd_in_ready@%0d: got %b expected %b", c, in_ready, er); end
            n_chk++; if (out_valid !== ev) begin n_fail++; $display("FAIL rnd_out_valid@%0d: got %b expected %b", c, out_valid, ev); end
            n_chk++; if (decode_count !== exp_cnt) begin n_fail++; $display("FAIL rnd_count@%0d: got %0d expected %0d", c, decode_count, exp_cnt); end
            n_chk++; if ({nm_in_ready, nm_out_valid, nm_decode_count} !== {er, ev, exp_cnt}) begin n_fail++; $display("FAIL rnd_nom_ctrl@%0d: got %b %b %0d expected %b %b %0d", c, nm_in_ready, nm_out_valid, nm_decode_count, er, ev, exp_cnt); end
            if (ev && out_ready) begin
                e = ref_dec(mq[0].instr, 1'b1);
                n_chk++; if (out_pc !== mq[0].pc || nm_out_pc !== mq[0].pc || got !== e) begin n_fail++; $display("FAIL rnd_bundle@%0d: got pc %h bundle %h expected pc %h bundle %h", c, out_pc, got, mq[0].pc, e); end
                void'(mq.pop_front());
                exp_cnt = exp_cnt + 1;
            end
            if (flush) mq.delete();
            else if (in_valid && er) begin
                mq.push_back(item_t'{instr: in_instr, pc: in_pc});
                pcn = pcn + 4;
            end
        end
        flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_decode();
        test_backpressure();
        test_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
